// File: rtl/alu_pkg.sv
// Shared encodings for the sequential accumulator ALU: FSM states,
// operation codes and accumulator-source selects.
package alu_pkg;

    // Control FSM states; the encoding is visible on the state output port.
    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_READY = 2'b01,
        S_RUN   = 2'b10,
        S_ERR   = 2'b11
    } state_e;

    // Operation codes presented on the op input.
    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOT  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_MUL  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // A-operand source on a start; 2'b11 behaves like SEL_PERSIST.
    typedef enum logic [1:0] {
        SEL_PERSIST = 2'b00,
        SEL_LOAD    = 2'b01,
        SEL_CLEAR   = 2'b10
    } sel_e;

endpackage

// File: rtl/seq_mult.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per
// product. done is high during the final step and product then already
// carries the completed sum, so the caller can capture it on that edge.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_sum;
    logic               w_last;

    assign w_addend = r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}};
    assign w_sum    = r_prod + w_addend;
    assign w_last   = r_busy && (r_cnt == CNT_W'(WIDTH - 1));

    // Operand latch on start, then one partial-product step per busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= {(2*WIDTH){1'b0}};
            r_prod   <= {(2*WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_busy   <= 1'b0;
        end else if (abort) begin
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_prod   <= {(2*WIDTH){1'b0}};
            r_mplier <= b;
            r_cnt    <= {CNT_W{1'b0}};
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_prod   <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            r_busy   <= ~w_last;
        end else begin
            r_busy   <= 1'b0;
        end
    end

    assign busy    = r_busy;
    assign done    = w_last;
    assign product = w_sum;

endmodule

// File: rtl/seq_alu_acc.sv
// Handshaked accumulator ALU. Single-cycle ops write the accumulator on
// the start edge; MUL runs through seq_mult while the FSM sits in RUN and
// parks in ERROR when the product does not fit in WIDTH bits.
module seq_alu_acc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic [1:0]       acc_sel,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             err_ack,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic             error,
    output logic [1:0]       state
);
    state_e             r_state;
    state_e             w_nxt_state;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   w_nxt_acc;
    logic [WIDTH-1:0]   w_a_opnd;
    logic               r_carry, w_nxt_carry;
    logic               r_zero,  w_nxt_zero;
    logic               r_done,  w_nxt_done;
    logic [WIDTH:0]     w_alu_res;
    logic               w_mult_start, w_mult_abort;
    logic               w_mult_busy,  w_mult_done;
    logic [2*WIDTH-1:0] w_mult_prod;

    // Single-cycle ALU; bit WIDTH is ADD carry-out or SUB borrow.
    function automatic logic [WIDTH:0] alu_calc(input logic [2:0] f_op,
                                                input logic [WIDTH-1:0] f_a,
                                                input logic [WIDTH-1:0] f_b);
        logic [WIDTH:0] v_res;
        v_res = {(WIDTH+1){1'b0}};
        case (f_op)
            OP_AND:  v_res = {1'b0, f_a & f_b};
            OP_OR:   v_res = {1'b0, f_a | f_b};
            OP_XOR:  v_res = {1'b0, f_a ^ f_b};
            OP_NOT:  v_res = {1'b0, ~f_a};
            OP_ADD:  v_res = {1'b0, f_a} + {1'b0, f_b};
            OP_SUB:  v_res = {1'b0, f_a} - {1'b0, f_b};
            OP_PASS: v_res = {1'b0, f_b};
            default: v_res = {(WIDTH+1){1'b0}};
        endcase
        return v_res;
    endfunction

    // A-operand source for the operation being started.
    always_comb begin
        case (acc_sel)
            SEL_LOAD:  w_a_opnd = num1;
            SEL_CLEAR: w_a_opnd = {WIDTH{1'b0}};
            default:   w_a_opnd = r_acc;
        endcase
    end

    assign w_alu_res = alu_calc(op, w_a_opnd, num2);

    seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mult_start),
        .a       (w_a_opnd),
        .b       (num2),
        .abort   (w_mult_abort),
        .busy    (w_mult_busy),
        .done    (w_mult_done),
        .product (w_mult_prod)
    );

    // Next-state, accumulator/flag update and multiplier control.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_acc    = r_acc;
        w_nxt_carry  = r_carry;
        w_nxt_zero   = r_zero;
        w_nxt_done   = 1'b0;
        w_mult_start = 1'b0;
        w_mult_abort = 1'b0;
        if (!on) begin
            // Power-down wins everywhere; a running multiply is dropped unwritten.
            w_nxt_state  = S_OFF;
            w_mult_abort = w_mult_busy;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_nxt_state = S_READY;
                end
                S_READY: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            w_mult_start = 1'b1;
                            w_nxt_state  = S_RUN;
                        end else begin
                            w_nxt_acc   = w_alu_res[WIDTH-1:0];
                            w_nxt_carry = w_alu_res[WIDTH];
                            w_nxt_zero  = (w_alu_res[WIDTH-1:0] == {WIDTH{1'b0}});
                            w_nxt_done  = 1'b1;
                        end
                    end else begin
                        w_nxt_state = S_READY;
                    end
                end
                S_RUN: begin
                    if (w_mult_done) begin
                        w_nxt_acc   = w_mult_prod[WIDTH-1:0];
                        w_nxt_carry = 1'b0;
                        w_nxt_zero  = (w_mult_prod[WIDTH-1:0] == {WIDTH{1'b0}});
                        w_nxt_done  = 1'b1;
                        if (w_mult_prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}) begin
                            w_nxt_state = S_ERR;
                        end else begin
                            w_nxt_state = S_READY;
                        end
                    end else if (!w_mult_busy) begin
                        // Multiplier idle while in RUN cannot make progress; recover.
                        w_nxt_state = S_READY;
                    end else begin
                        w_nxt_state = S_RUN;
                    end
                end
                S_ERR: begin
                    if (err_ack) begin
                        w_nxt_state = S_READY;
                    end else begin
                        w_nxt_state = S_ERR;
                    end
                end
                default: begin
                    w_nxt_state = S_READY;
                end
            endcase
        end
    end

    // State, accumulator and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_READY;
            r_acc   <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_acc   <= w_nxt_acc;
            r_carry <= w_nxt_carry;
            r_zero  <= w_nxt_zero;
            r_done  <= w_nxt_done;
        end
    end

    assign result = r_acc;
    assign carry  = r_carry;
    assign zero   = r_zero;
    assign done   = r_done;
    assign busy   = (r_state == S_RUN);
    assign error  = (r_state == S_ERR);
    assign state  = r_state;

endmodule
